// File: rtl/ddr_burst_wr_ctrl.sv
// Drains fixed-length bursts from a 256-bit store FIFO onto AXI write; one beat per 3 cycles (pop, read latency, W handshake).
// Backpressure: AW, W and B each hold their state until awready / wready / bvalid; no pop is issued while a beat waits in W.
module ddr_burst_wr_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0010_0000
) (
  input  logic         axi_clk,
  input  logic         rst,
  input  logic [7:0]   alen,
  input  logic [9:0]   occupants,
  output logic         fifo_rd_en,
  input  logic [255:0] fifo_rdata,
  input  logic         fifo_rvalid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         awvalid,
  input  logic         awready,
  output logic [255:0] wdata,
  output logic         wvalid,
  input  logic         wready,
  output logic         wlast,
  input  logic         bvalid,
  input  logic [1:0]   bresp,
  output logic         bready,
  output logic         busy,
  output logic         err,
  output logic [15:0]  burst_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AW      = 3'd1,
    FETCH   = 3'd2,
    WAIT_RV = 3'd3,
    W       = 3'd4,
    B       = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  beat;
  logic        start;
  logic [32:0] cur_bytes;
  logic [32:0] nxt_bytes;
  logic [32:0] adv_sum;
  logic [32:0] exit_sum;

  // alen+1 tops out at 256, so the 10-bit compare cannot overflow
  assign start     = occupants >= ({2'b00, alen} + 10'd1);
  assign cur_bytes = ({25'd0, awlen} + 33'd1) << 5;
  assign nxt_bytes = ({25'd0, alen} + 33'd1) << 5;
  assign adv_sum   = {1'b0, awaddr} + cur_bytes;
  assign exit_sum  = {1'b0, awaddr} + nxt_bytes;

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = AW;
      AW:      if (awready)     state_nxt = FETCH;
      FETCH:                    state_nxt = WAIT_RV;
      WAIT_RV: if (fifo_rvalid) state_nxt = W;
      W:       if (wready)      state_nxt = wlast ? B : FETCH;
      B:       if (bvalid)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    awvalid    = 1'b0;
    fifo_rd_en = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      AW:      begin awvalid = 1'b1; busy = 1'b1; end
      FETCH:   begin fifo_rd_en = 1'b1; busy = 1'b1; end
      WAIT_RV: busy = 1'b1;
      W:       begin wvalid = 1'b1; busy = 1'b1; end
      B:       begin bready = 1'b1; busy = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      awaddr    <= BASE_ADDR;
      awlen     <= 8'd0;
      beat      <= 8'd0;
      wdata     <= '0;
      wlast     <= 1'b0;
      burst_cnt <= 16'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            awlen <= alen;
            beat  <= 8'd0;
            // window check uses the length being latched now, not the previous burst's
            if (exit_sum[32] || (exit_sum > {1'b0, ADDR_LIMIT})) begin
              awaddr <= BASE_ADDR;
            end
          end
        end
        WAIT_RV: begin
          if (fifo_rvalid) begin
            wdata <= fifo_rdata;
            wlast <= (beat == awlen);
          end
        end
        W: begin
          if (wready) begin
            if (wlast) begin
              wlast <= 1'b0;
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        B: begin
          if (bvalid) begin
            burst_cnt <= burst_cnt + 16'd1;
            if (bresp != 2'b00) begin
              err <= 1'b1;
            end
            awaddr <= adv_sum[32] ? BASE_ADDR : adv_sum[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_wr_ctrl.sv
// Directed bench for ddr_burst_wr_ctrl with a 256-byte window at address 0; the FIFO responder
// returns a numbered data word one cycle after every pop.
module tb_ddr_burst_wr_ctrl;

  logic         axi_clk;
  logic         rst;
  logic [7:0]   alen;
  logic [9:0]   occupants;
  logic         fifo_rd_en;
  logic [255:0] fifo_rdata;
  logic         fifo_rvalid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready;
  logic [255:0] wdata;
  logic         wvalid;
  logic         wready;
  logic         wlast;
  logic         bvalid;
  logic [1:0]   bresp;
  logic         bready;
  logic         busy;
  logic         err;
  logic [15:0]  burst_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int pop_cnt = 0;
  int viol   = 0;
  int pend_idx = 0;
  bit pend   = 0;

  ddr_burst_wr_ctrl #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_LIMIT(32'd256)
  ) dut (
    .axi_clk    (axi_clk),
    .rst        (rst),
    .alen       (alen),
    .occupants  (occupants),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_rvalid(fifo_rvalid),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .wlast      (wlast),
    .bvalid     (bvalid),
    .bresp      (bresp),
    .bready     (bready),
    .busy       (busy),
    .err        (err),
    .burst_cnt  (burst_cnt)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] data_of(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  // FIFO responder: data appears one cycle after each pop, numbered by pop order
  initial begin
    fifo_rvalid = 1'b0;
    fifo_rdata  = '0;
    forever begin
      @(negedge axi_clk);
      fifo_rvalid = pend;
      fifo_rdata  = pend ? data_of(pend_idx) : '0;
      pend = 1'b0;
      if (fifo_rd_en) begin
        pend     = 1'b1;
        pend_idx = pop_cnt;
        pop_cnt++;
        if (wvalid) viol++;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awaddr"},  awaddr, 32'h0);
    chk({tag, "_awlen"},   awlen, 8'h0);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
    chk({tag, "_rd_en"},   fifo_rd_en, 1'b0);
    chk({tag, "_wdata"},   wdata, '0);
    chk({tag, "_wvalid"},  wvalid, 1'b0);
    chk({tag, "_wlast"},   wlast, 1'b0);
    chk({tag, "_bready"},  bready, 1'b0);
    chk({tag, "_busy"},    busy, 1'b0);
    chk({tag, "_err"},     err, 1'b0);
    chk({tag, "_cnt"},     burst_cnt, 16'h0);
  endtask

  task automatic run_burst(input logic [31:0] exp_addr, input logic [7:0] len,
                           input logic [1:0] resp, input int stall_beat, input int abort_beat,
                           input logic [15:0] exp_cnt, input logic exp_err,
                           input logic [31:0] exp_next);
    int p0;
    int p_ab;
    bit seen;
    p0 = pop_cnt;
    bresp = resp;
    alen = len;
    occupants = {2'b00, len} + 10'd1;
    @(negedge axi_clk);
    chk("start_busy", busy, 1'b1);
    chk("awvalid", awvalid, 1'b1);
    chk("awaddr", awaddr, exp_addr);
    chk("awlen", awlen, len);
    occupants = 10'd0;
    alen = ~len;
    for (int b = 0; b <= int'(len); b++) begin
      seen = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
        @(negedge axi_clk);
        seen = wvalid;
      end
      if (!seen) begin
        chk("wvalid_timeout", 1'b0, 1'b1);
        return;
      end
      chk("wdata", wdata, data_of(p0 + b));
      chk("wlast", wlast, b == int'(len));
      if (b == abort_beat) begin
        rst = 1'b0;
        #1;
        chk("abort_wvalid", wvalid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_awaddr", awaddr, 32'h0);
        chk("abort_wlast", wlast, 1'b0);
        p_ab = pop_cnt;
        repeat (3) @(negedge axi_clk);
        rst = 1'b1;
        repeat (2) @(negedge axi_clk);
        chk("abort_no_pops", pop_cnt, p_ab);
        chk("abort_idle", busy, 1'b0);
        chk("abort_cnt", burst_cnt, 16'h0);
        return;
      end
      if (b == stall_beat) begin
        wready = 1'b0;
        repeat (10) begin
          @(negedge axi_clk);
          chk("stall_wvalid", wvalid, 1'b1);
          chk("stall_wdata", wdata, data_of(p0 + b));
          chk("stall_rd_en", fifo_rd_en, 1'b0);
        end
        wready = 1'b1;
      end
    end
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge axi_clk);
      seen = !busy;
    end
    chk("done_timeout", seen, 1'b1);
    chk("burst_cnt", burst_cnt, exp_cnt);
    chk("err", err, exp_err);
    chk("pops", pop_cnt - p0, int'(len) + 1);
    chk("next_awaddr", awaddr, exp_next);
  endtask

  initial begin
    rst = 1'b0;
    alen = 8'd0;
    occupants = 10'd0;
    awready = 1'b1;
    wready = 1'b1;
    bvalid = 1'b1;
    bresp = 2'b00;
    repeat (3) @(negedge axi_clk);
    chk_reset_outputs("rst");
    rst = 1'b1;
    @(negedge axi_clk);

    // basic 4-beat burst
    run_burst(32'd0, 8'd3, 2'b00, -1, -1, 16'd1, 1'b0, 32'd128);

    // not enough words: one and three short of an 8-beat burst
    alen = 8'd7;
    occupants = 10'd5;
    repeat (4) begin
      @(negedge axi_clk);
      chk("short_busy", busy, 1'b0);
      chk("short_rd_en", fifo_rd_en, 1'b0);
    end
    occupants = 10'd7;
    @(negedge axi_clk);
    chk("short7_busy", busy, 1'b0);
    // 128 + 256 exceeds the window, so this burst wraps to 0
    run_burst(32'd0, 8'd7, 2'b00, -1, -1, 16'd2, 1'b0, 32'd256);

    // W backpressure on beat 1; 256 + 128 wraps
    run_burst(32'd0, 8'd3, 2'b00, 1, -1, 16'd3, 1'b0, 32'd128);

    // reset while beat 2 sits in W
    run_burst(32'd128, 8'd3, 2'b00, -1, 2, 16'd0, 1'b0, 32'd0);

    // back-to-back bursts, equal-to-limit then wrap
    run_burst(32'd0,   8'd3, 2'b00, -1, -1, 16'd1, 1'b0, 32'd128);
    run_burst(32'd128, 8'd3, 2'b00, -1, -1, 16'd2, 1'b0, 32'd256);
    run_burst(32'd0,   8'd3, 2'b00, -1, -1, 16'd3, 1'b0, 32'd128);

    rst = 1'b0;
    #1;
    chk("pulse_cnt", burst_cnt, 16'h0);
    chk("pulse_awaddr", awaddr, 32'h0);
    @(negedge axi_clk);
    rst = 1'b1;
    @(negedge axi_clk);

    // SLVERR then OKAY: err sticks
    run_burst(32'd0,   8'd3, 2'b10, -1, -1, 16'd1, 1'b1, 32'd128);
    run_burst(32'd128, 8'd3, 2'b00, -1, -1, 16'd2, 1'b1, 32'd256);
    repeat (3) @(negedge axi_clk);
    chk("err_sticky", err, 1'b1);

    rst = 1'b0;
    #1;
    chk_reset_outputs("final");
    @(negedge axi_clk);
    rst = 1'b1;
    chk("rd_en_vs_wvalid", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
